// File: rtl/action_exec_fsm.sv
// action_exec_fsm
// Executes the action chosen by the upstream action counter. The raw confirm and cancel
// push-buttons are synchronised and debounced. A debounced confirm press in IDLE latches
// act_idx_i and drives the selected action one-hot for HOLD_CYCLES cycles. Completion
// raises done_o together with a one-cycle cnt_rst_o back to the counter.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_i          synchronous, active-high reset
//   act_idx_i      action index {Q1,Q0}; 0..2 legal, 3 illegal
//   confirm_btn_i  raw confirm button, active-high, asynchronous
//   cancel_btn_i   raw cancel button, active-high, asynchronous
//   busy_o         high in EXEC and DONE
//   act_valid_o    high in EXEC
//   act_onehot_o   1 << latched index while act_valid_o, else 0
//   done_o         one-cycle pulse at the end of a hold window
//   cnt_rst_o      one-cycle pulse coincident with done_o
//   err_o          sticky flag: confirm seen with act_idx_i == 3
module action_exec_fsm #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES     = 8,
    parameter int unsigned HOLD_W          = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] act_idx_i,
    input  logic       confirm_btn_i,
    input  logic       cancel_btn_i,
    output logic       busy_o,
    output logic       act_valid_o,
    output logic [2:0] act_onehot_o,
    output logic       done_o,
    output logic       cnt_rst_o,
    output logic       err_o
);

    localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned BtnConfirm = 0;
    localparam int unsigned BtnCancel  = 1;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StDone
    } state_e;

    // ---------------------------------------------------------------------------------
    // Input conditioning, one lane per button (0 = confirm, 1 = cancel)
    // ---------------------------------------------------------------------------------
    logic [1:0]                  raw_btn;
    logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0][DbW-1:0]         db_cnt_q, db_cnt_d;
    logic [1:0]                  db_lvl_q, db_lvl_d;
    logic [1:0]                  evt_q, evt_d;

    assign raw_btn = {cancel_btn_i, confirm_btn_i};

    always_comb begin
        sync_d   = sync_q;
        db_cnt_d = db_cnt_q;
        db_lvl_d = db_lvl_q;
        evt_d    = '0;
        for (int b = 0; b < 2; b++) begin
            sync_d[b] = {sync_q[b][SYNC_STAGES-2:0], raw_btn[b]};
            if (sync_q[b][SYNC_STAGES-1] != db_lvl_q[b]) begin
                // Flip on the DEBOUNCE_CYCLES-th consecutive differing sample.
                if (db_cnt_q[b] == DbW'(DEBOUNCE_CYCLES - 1)) begin
                    db_lvl_d[b] = sync_q[b][SYNC_STAGES-1];
                    db_cnt_d[b] = '0;
                    evt_d[b]    = sync_q[b][SYNC_STAGES-1];  // rising edges only
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + DbW'(1);
                end
            end else begin
                db_cnt_d[b] = '0;
            end
        end
    end

    // ---------------------------------------------------------------------------------
    // Execution FSM
    // ---------------------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              err_q, err_d;

    logic       busy_q, busy_d;
    logic       act_valid_q, act_valid_d;
    logic [2:0] act_onehot_q, act_onehot_d;
    logic       done_q, done_d;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        hold_d  = hold_q;
        err_d   = err_q;

        case (state_q)
            StIdle: begin
                if (evt_q[BtnConfirm]) begin
                    if (act_idx_i == 2'd3) begin
                        err_d = 1'b1;
                    end else begin
                        sel_d   = act_idx_i;
                        hold_d  = HOLD_W'(HOLD_CYCLES - 1);
                        err_d   = 1'b0;
                        state_d = StExec;
                    end
                end
            end
            StExec: begin
                // Cancel takes priority over hold expiry.
                if (evt_q[BtnCancel]) begin
                    state_d = StIdle;
                end else if (hold_q == '0) begin
                    state_d = StDone;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        busy_d       = (state_d != StIdle);
        act_valid_d  = (state_d == StExec);
        act_onehot_d = act_valid_d ? (3'b001 << sel_d) : 3'b000;
        done_d       = (state_d == StDone);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q       <= '0;
            db_cnt_q     <= '0;
            db_lvl_q     <= '0;
            evt_q        <= '0;
            state_q      <= StIdle;
            sel_q        <= '0;
            hold_q       <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            act_valid_q  <= 1'b0;
            act_onehot_q <= 3'b000;
            done_q       <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            db_cnt_q     <= db_cnt_d;
            db_lvl_q     <= db_lvl_d;
            evt_q        <= evt_d;
            state_q      <= state_d;
            sel_q        <= sel_d;
            hold_q       <= hold_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            act_valid_q  <= act_valid_d;
            act_onehot_q <= act_onehot_d;
            done_q       <= done_d;
        end
    end

    assign busy_o       = busy_q;
    assign act_valid_o  = act_valid_q;
    assign act_onehot_o = act_onehot_q;
    assign done_o       = done_q;
    assign cnt_rst_o    = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_action_exec_fsm.sv
// tb_action_exec_fsm
// Directed scenarios plus randomized button/index traffic, checked every cycle against a
// behavioural model of the conditioning and execution rules.
module tb_action_exec_fsm;

    localparam int unsigned SYNC = 2;
    localparam int unsigned DEB  = 4;
    localparam int unsigned HOLD = 8;

    logic       clk;
    logic       rst;
    logic [1:0] act_idx;
    logic       confirm_btn;
    logic       cancel_btn;
    logic       busy;
    logic       act_valid;
    logic [2:0] act_onehot;
    logic       done;
    logic       cnt_rst;
    logic       err;

    action_exec_fsm #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD),
        .HOLD_W         (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .act_idx_i    (act_idx),
        .confirm_btn_i(confirm_btn),
        .cancel_btn_i (cancel_btn),
        .busy_o       (busy),
        .act_valid_o  (act_valid),
        .act_onehot_o (act_onehot),
        .done_o       (done),
        .cnt_rst_o    (cnt_rst),
        .err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int dut_done_n = 0;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_on = 0;
    bit pipe [2][SYNC];   // raw samples still travelling through the synchroniser
    bit win  [2][DEB];    // most recent synced samples seen by the debouncer
    bit m_lvl[2];
    bit m_evt[2];
    int m_phase;          // 0 idle, 1 executing, 2 done
    int m_left;           // executing cycles still to come, including the current one
    int m_sel;
    bit m_err;

    always @(posedge clk) begin
        bit raw[2];
        bit s;
        bit all_diff;
        if (rst) begin
            m_on = 1;
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < SYNC; k++) pipe[b][k] = 0;
                for (int k = 0; k < DEB; k++)  win[b][k]  = 0;
                m_lvl[b] = 0;
                m_evt[b] = 0;
            end
            m_phase = 0;
            m_left  = 0;
            m_sel   = 0;
            m_err   = 0;
        end else begin
            case (m_phase)
                0: if (m_evt[0]) begin
                    if (act_idx == 2'd3) m_err = 1;
                    else begin
                        m_sel   = int'(act_idx);
                        m_left  = HOLD;
                        m_err   = 0;
                        m_phase = 1;
                    end
                end
                1: begin
                    if (m_evt[1])         m_phase = 0;
                    else if (m_left == 1) m_phase = 2;
                    else                  m_left--;
                end
                default: m_phase = 0;
            endcase
            raw[0] = confirm_btn;
            raw[1] = cancel_btn;
            for (int b = 0; b < 2; b++) begin
                s = pipe[b][SYNC-1];
                for (int k = SYNC - 1; k > 0; k--) pipe[b][k] = pipe[b][k-1];
                pipe[b][0] = raw[b];
                for (int k = DEB - 1; k > 0; k--) win[b][k] = win[b][k-1];
                win[b][0] = s;
                all_diff = 1;
                for (int k = 0; k < DEB; k++) if (win[b][k] == m_lvl[b]) all_diff = 0;
                m_evt[b] = 0;
                if (all_diff) begin
                    m_lvl[b] = s;
                    m_evt[b] = s;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        cyc++;
        if (done) dut_done_n++;
        if (m_on) begin
            chk("busy",       int'(busy),       int'(m_phase != 0));
            chk("act_valid",  int'(act_valid),  int'(m_phase == 1));
            chk("act_onehot", int'(act_onehot), (m_phase == 1) ? (1 << m_sel) : 0);
            chk("done",       int'(done),       int'(m_phase == 2));
            chk("cnt_rst",    int'(cnt_rst),    int'(m_phase == 2));
            chk("err",        int'(err),        int'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic settle();
        confirm_btn = 1'b0;
        cancel_btn  = 1'b0;
        tick(25);
    endtask

    int base;
    int c_len, x_len;

    initial begin
        rst = 1'b1; act_idx = 2'd0; confirm_btn = 1'b0; cancel_btn = 1'b0;
        tick(3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(act_valid), 0);
        chk("rst_err", int'(err), 0);
        rst = 1'b0;
        settle();

        // Latency, hold window, done/cnt_rst pulse.
        base = dut_done_n;
        act_idx = 2'd2; confirm_btn = 1'b1;
        tick(6);
        chk("t2_valid_e6", int'(act_valid), 0);
        tick(1);
        chk("t2_valid_e7", int'(act_valid), 1);
        chk("t2_onehot", int'(act_onehot), 4);
        tick(3);
        confirm_btn = 1'b0;
        tick(4);
        chk("t2_valid_e14", int'(act_valid), 1);
        tick(1);
        chk("t2_done_e15", int'(done), 1);
        chk("t2_cntrst_e15", int'(cnt_rst), 1);
        chk("t2_valid_e15", int'(act_valid), 0);
        tick(1);
        chk("t2_busy_e16", int'(busy), 0);
        settle();
        chk("t2_done_cnt", dut_done_n - base, 1);

        // Reset mid-EXEC.
        base = dut_done_n;
        act_idx = 2'd0; confirm_btn = 1'b1;
        tick(9);
        chk("t1_valid_pre", int'(act_valid), 1);
        rst = 1'b1;
        tick(3);
        chk("t1_busy", int'(busy), 0);
        chk("t1_onehot", int'(act_onehot), 0);
        rst = 1'b0; confirm_btn = 1'b0;
        settle();
        chk("t1_no_done", dut_done_n - base, 0);

        // Glitch shorter than the debounce window.
        confirm_btn = 1'b1;
        tick(3);
        confirm_btn = 1'b0;
        tick(15);
        chk("t3_valid", int'(act_valid), 0);
        chk("t3_busy", int'(busy), 0);
        settle();

        // Illegal index, then a legal one clears err.
        act_idx = 2'd3; confirm_btn = 1'b1;
        tick(7);
        chk("t4_err_set", int'(err), 1);
        chk("t4_valid", int'(act_valid), 0);
        confirm_btn = 1'b0;
        tick(12);
        act_idx = 2'd1; confirm_btn = 1'b1;
        tick(7);
        chk("t4_err_clr", int'(err), 0);
        chk("t4_onehot", int'(act_onehot), 2);
        settle();

        // Cancel event acted on after the 4th EXEC cycle.
        base = dut_done_n;
        act_idx = 2'd0; confirm_btn = 1'b1;
        tick(4);
        cancel_btn = 1'b1;
        tick(6);
        chk("t5_valid_e10", int'(act_valid), 1);
        tick(1);
        chk("t5_valid_e11", int'(act_valid), 0);
        chk("t5_busy_e11", int'(busy), 0);
        settle();
        chk("t5_no_done", dut_done_n - base, 0);

        // Index change and second confirm during EXEC are ignored.
        base = dut_done_n;
        act_idx = 2'd0; confirm_btn = 1'b1;
        tick(4);
        confirm_btn = 1'b0;
        tick(3);
        act_idx = 2'd1;
        tick(1);
        confirm_btn = 1'b1;
        tick(3);
        chk("t6_onehot", int'(act_onehot), 1);
        tick(8);
        settle();
        chk("t6_one_done", dut_done_n - base, 1);

        // Randomized traffic.
        c_len = 1; x_len = 1;
        for (int i = 0; i < 4000; i++) begin
            if (--c_len == 0) begin
                confirm_btn = ($urandom_range(0, 1) == 1);
                c_len = $urandom_range(1, 12);
            end
            if (--x_len == 0) begin
                cancel_btn = ($urandom_range(0, 3) == 0);
                x_len = $urandom_range(1, 12);
            end
            if ($urandom_range(0, 7) == 0) act_idx = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        rst = 1'b0;
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
